click_decoder: RTL

CLICK_DECODER -- requirements
Module: click_decoder

---
 rtl/click_if.sv | 10 +
 rtl/click_decoder.sv | 87 ++++++++
 2 files changed

// File: rtl/click_if.sv
// Click-decoder handshake: debounced click pulses in, classified click events out.
interface click_if;
  logic       pulse_in;
  logic       evt;
  logic [1:0] clicks;
  logic       busy;

  modport master (output pulse_in, input evt, clicks, busy);
  modport slave  (input pulse_in, output evt, clicks, busy);
endinterface

// File: rtl/click_decoder.sv
// Groups debounced click pulses into single/double/triple sequences and reports
// the count once the inter-click window expires or the maximum count is reached.
module click_decoder #(
  parameter int WINDOW_BITS = 22,
  parameter int MAX_CLICKS  = 3
) (
  input  logic   clk,
  input  logic   rst,
  click_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COUNT, EMIT} state_t;

  localparam logic [1:0]             MAX_CNT = 2'(MAX_CLICKS);
  localparam logic [WINDOW_BITS-1:0] TERM    = '1;

  // Declaration initialisers give power-up values identical to the reset values.
  state_t                 state  = IDLE;
  logic [1:0]             cnt    = 2'd0;
  logic [WINDOW_BITS-1:0] timer  = '0;
  logic                   evt_q  = 1'b0;
  logic [1:0]             clicks_q = 2'd0;
  logic                   busy_q = 1'b0;

  logic [1:0] cnt_inc;
  assign cnt_inc = cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      timer    <= '0;
      evt_q    <= 1'b0;
      clicks_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      case (state)
        // EMIT behaves like IDLE on a fresh pulse, so back-to-back sequences lose nothing.
        IDLE, EMIT: begin
          if (bus.pulse_in) begin
            cnt    <= 2'd1;
            timer  <= '0;
            busy_q <= 1'b1;
            if (MAX_CNT == 2'd1) begin
              state    <= EMIT;
              evt_q    <= 1'b1;
              clicks_q <= 2'd1;
            end else begin
              state <= COUNT;
            end
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        // A pulse on the terminal timer cycle still counts and restarts the window.
        COUNT: begin
          if (bus.pulse_in) begin
            cnt   <= cnt_inc;
            timer <= '0;
            if (cnt_inc == MAX_CNT) begin
              state    <= EMIT;
              evt_q    <= 1'b1;
              clicks_q <= cnt_inc;
            end
          end else if (timer != TERM) begin
            timer <= timer + 1'b1;
          end else begin
            state    <= EMIT;
            evt_q    <= 1'b1;
            clicks_q <= cnt;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.evt    = evt_q;
  assign bus.clicks = clicks_q;
  assign bus.busy   = busy_q;

endmodule
